sram_a_loader: RTL

- Host-side writer for the SRAM A image banks (a0..a8) that the LeNet accelerator core reads during convolution.
- Accepts a row-major pixel stream. Each beat carries one pixel for set 0 and one pixel for set 1.
- Scatters each pixel pair into the 3x3-interleaved bank layout with a single-byte masked write.
- After the last pixel, pulses conv_start, then waits for fc2_done before accepting the next image pair.

---
 rtl/lenet_pkg.sv | 23 ++
 rtl/sram_a_addr_gen.sv | 82 ++++++++
 rtl/sram_a_loader.sv | 114 +++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet accelerator host-side logic:
// the SRAM A loader FSM states and the default image/SRAM geometry.
package lenet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        START,
        WAIT
    } loader_state_t;

    localparam int IMG_W_DEF     = 28;
    localparam int IMG_H_DEF     = 28;
    localparam int SRAM_A_BANKS  = 9;
    localparam int SRAM_A_ADDR_W = 10;

    // Words per bank row: each bank word covers 4 pixels and the 3 column banks interleave.
    function automatic int words_per_row(input int img_w);
        return (img_w + 11) / 12;
    endfunction

endpackage

// File: rtl/sram_a_addr_gen.sv
// Pixel position tracker for the SRAM A loader: turns a row-major beat sequence
// into bank / word address / byte lane using incremental mod-3 counters only.
module sram_a_addr_gen
    import lenet_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = SRAM_A_ADDR_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clear,
    input  logic              advance,
    output logic [3:0]        bank,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        lane,
    output logic              last_pix
);

    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H > 1 ? IMG_H : 2);
    localparam int WPR = words_per_row(IMG_W);

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [1:0]        wc_mod3;
    logic [ADDR_W-1:0] wc_div3;
    logic [1:0]        y_mod3;
    logic [ADDR_W-1:0] row_base;
    logic              x_last;
    logic              y_last;

    assign x_last = (x == XW'(IMG_W - 1));
    assign y_last = (y == YW'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            x        <= '0;
            y        <= '0;
            wc_mod3  <= '0;
            wc_div3  <= '0;
            y_mod3   <= '0;
            row_base <= '0;
        end else if (advance) begin
            if (x_last) begin
                x       <= '0;
                wc_mod3 <= '0;
                wc_div3 <= '0;
                if (y_last) begin
                    y        <= '0;
                    y_mod3   <= '0;
                    row_base <= '0;
                end else begin
                    y <= y + YW'(1);
                    // Every third row starts a new band of words in each bank.
                    if (y_mod3 == 2'd2) begin
                        y_mod3   <= '0;
                        row_base <= row_base + ADDR_W'(WPR);
                    end else begin
                        y_mod3 <= y_mod3 + 2'd1;
                    end
                end
            end else begin
                x <= x + XW'(1);
                if (x[1:0] == 2'd3) begin
                    if (wc_mod3 == 2'd2) begin
                        wc_mod3 <= '0;
                        wc_div3 <= wc_div3 + ADDR_W'(1);
                    end else begin
                        wc_mod3 <= wc_mod3 + 2'd1;
                    end
                end
            end
        end
    end

    assign bank     = ({2'b00, y_mod3} << 1) + {2'b00, y_mod3} + {2'b00, wc_mod3};
    assign addr     = row_base + wc_div3;
    assign lane     = x[1:0];
    assign last_pix = x_last && y_last;

endmodule

// File: rtl/sram_a_loader.sv
// Host-side SRAM A image writer: scatters a row-major pixel-pair stream into the
// 3x3-interleaved banks, then kicks the accelerator and waits for fc2_done.
module sram_a_loader
    import lenet_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = SRAM_A_ADDR_W,
    parameter int BANKS  = SRAM_A_BANKS
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load_req,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    output logic              pix_ready,
    output logic [BANKS-1:0]  sram_write_enable_a,
    output logic [3:0]        sram_bytemask_a,
    output logic [ADDR_W-1:0] sram_waddr_a,
    output logic [7:0]        sram_wdata_a,
    output logic [7:0]        sram_wdata_a_1,
    output logic              conv_start,
    input  logic              fc2_done,
    output logic              busy,
    output logic              done
);

    loader_state_t     state;
    logic              accept;
    logic              start_load;
    logic [3:0]        cur_bank;
    logic [ADDR_W-1:0] cur_addr;
    logic [1:0]        cur_lane;
    logic              last_pix;

    // pix_ready is registered and high only in LOAD, so it doubles as the state qualifier.
    assign accept     = pix_valid && pix_ready;
    assign start_load = (state == IDLE) && load_req;

    sram_a_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .srst     (srst),
        .clear    (start_load),
        .advance  (accept),
        .bank     (cur_bank),
        .addr     (cur_addr),
        .lane     (cur_lane),
        .last_pix (last_pix)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state               <= IDLE;
            pix_ready           <= 1'b0;
            sram_write_enable_a <= '1;
            sram_bytemask_a     <= '1;
            sram_waddr_a        <= '0;
            sram_wdata_a        <= '0;
            sram_wdata_a_1      <= '0;
            conv_start          <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            // NOTE: strobes default to inactive here and are overridden below; with
            // non-blocking assignments the last assignment in the block wins.
            sram_write_enable_a <= '1;
            sram_bytemask_a     <= '1;
            conv_start          <= 1'b0;
            done                <= 1'b0;

            if (accept) begin
                sram_write_enable_a <= ~(BANKS'(1) << cur_bank);
                sram_bytemask_a     <= ~(4'b0001 << cur_lane);
                sram_waddr_a        <= cur_addr;
                sram_wdata_a        <= pix_data[7:0];
                sram_wdata_a_1      <= pix_data[15:8];
            end

            case (state)
                IDLE: begin
                    if (load_req) begin
                        state     <= LOAD;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept && last_pix) begin
                        state     <= FLUSH;
                        pix_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    state      <= START;
                    conv_start <= 1'b1;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (fc2_done) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
